ifetch_queue: RTL and testbench

Instruction fetch queue sitting between the fetch-PC logic and `itlb_icache`. It generates sequential word-aligned fetch requests, holds the cache request stable across stalls, and buffers returned instructions with their PC and fault code in a small FIFO for the decode stage. It also absorbs redirects (branches/exceptions) and discards any in-flight response.

---
 rtl/ifetch_queue.sv | 169 ++++++++++++++++
 tb/tb_ifetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a small output FIFO.
// Issues word-aligned requests to the I-cache, holds each request stable until
// ic_valid, and queues {pc, instr, fault} for decode. Redirects flush the queue.
// An outstanding response at redirect time is waited out and then dropped.
// Optional feature macro: IFETCH_QUEUE_BYPASS_EN (zero-latency bypass when empty).
module ifetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = 32'hfff00100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        ic_read_strobe,
  output logic [31:0] ic_read_addr,
  input  logic [31:0] ic_read_data,
  input  logic        ic_valid,
  input  logic        ic_stall,
  input  logic [2:0]  ic_fault,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  out_fault,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] redirect_target;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [2:0]  mem_fault [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic strobe;
  logic complete;
  logic accept;
  logic fifo_valid;
  logic bypass_valid;
  logic bypass_take;
  logic push;
  logic pop;
  logic [31:0] push_instr;

  // ic_stall is advisory only; the low address bits of a redirect are discarded
  logic unused_inputs;
  assign unused_inputs = ^{ic_stall, redirect_addr[1:0]};

  assign redirect_target = {redirect_addr[31:2], 2'b00};

  // Request handshake and push/pop qualification
  always_comb begin
    complete     = strobe && ic_valid;
    accept       = complete && (state == S_FETCH) && !redirect;
    fifo_valid   = (count != '0);
`ifdef IFETCH_QUEUE_BYPASS_EN
    bypass_valid = !fifo_valid && accept;
`else
    bypass_valid = 1'b0;
`endif
    bypass_take  = bypass_valid && out_ready;
    push         = accept && !bypass_take;
    pop          = fifo_valid && out_ready && !redirect;
    push_instr   = (ic_fault == 3'd0) ? ic_read_data : 32'h0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = (strobe && !ic_valid) ? S_DISCARD : S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (accept && (ic_fault != 3'd0)) state_next = S_HALT;
        S_DISCARD: if (ic_valid) state_next = S_FETCH;
        S_HALT:    state_next = S_HALT;
        default:   state_next = S_FETCH;
      endcase
    end
  end

  // FSM outputs: strobe drops in the reset cycle itself
  always_comb begin
    strobe = 1'b0;
    if (!reset) begin
      strobe = ((state == S_FETCH) && (count < CW'(DEPTH))) || (state == S_DISCARD);
    end
    ic_read_strobe = strobe;
    ic_read_addr   = pc;
  end

  // Fetch PC and deferred redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      pend_pc <= 32'h0;
    end else if (redirect) begin
      if (strobe && !ic_valid) pend_pc <= redirect_target;
      else                     pc      <= redirect_target;
    end else if ((state == S_DISCARD) && ic_valid) begin
      pc <= pend_pc;
    end else if (accept && (ic_fault == 3'd0)) begin
      pc <= pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= pc;
      mem_fault[wr_ptr] <= ic_fault;
    end
  end

  // Head presentation; fields read zero when nothing is valid
  always_comb begin
    out_valid = fifo_valid || bypass_valid;
    out_instr = 32'h0;
    out_pc    = 32'h0;
    out_fault = 3'd0;
    if (fifo_valid) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
      out_fault = mem_fault[rd_ptr];
    end else if (bypass_valid) begin
      out_instr = push_instr;
      out_pc    = pc;
      out_fault = ic_fault;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default build, bypass disabled).
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        ic_read_strobe;
  logic [31:0] ic_read_addr;
  logic [31:0] ic_read_data;
  logic        ic_valid;
  logic        ic_stall;
  logic [2:0]  ic_fault;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_fault;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_queue #(.DEPTH(4), .RESET_VECTOR(32'hfff00100)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .ic_read_strobe(ic_read_strobe), .ic_read_addr(ic_read_addr),
    .ic_read_data(ic_read_data), .ic_valid(ic_valid), .ic_stall(ic_stall),
    .ic_fault(ic_fault), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic        v;
    logic [31:0] d;
    logic [2:0]  f;
    logic        rdy;
    logic        stl;
    logic        e_stb;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_flt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic [31:0] ra, input logic v,
                     input logic [31:0] d, input logic [2:0] f, input logic rdy,
                     input logic stl, input logic e_stb, input logic [31:0] e_addr,
                     input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [2:0] e_flt);
    vec_t r;
    r.rd = rd; r.ra = ra; r.v = v; r.d = d; r.f = f; r.rdy = rdy; r.stl = stl;
    r.e_stb = e_stb; r.e_addr = e_addr; r.e_ov = e_ov; r.e_pc = e_pc;
    r.e_ins = e_ins; r.e_flt = e_flt;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic rd, input logic [31:0] ra,
                       input logic v, input logic [31:0] d, input logic [2:0] f,
                       input logic rdy, input logic stl);
    reset = rst; redirect = rd; redirect_addr = ra; ic_valid = v;
    ic_read_data = d; ic_fault = f; out_ready = rdy; ic_stall = stl;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

    // Cycle-by-cycle script: inputs | expected strobe, addr, out_valid, out_pc, out_instr, out_fault
    // Back-to-back hits from reset vector
    add(0, 0, 1, 32'hfff00100, 0, 1, 0,  1, 32'hfff00100, 0, 0, 0, 0);
    add(0, 0, 1, 32'hfff00104, 0, 1, 0,  1, 32'hfff00104, 1, 32'hfff00100, 32'hfff00100, 0);
    add(0, 0, 1, 32'hfff00108, 0, 1, 0,  1, 32'hfff00108, 1, 32'hfff00104, 32'hfff00104, 0);
    // Consumer stops: fill to DEPTH, strobe falls at count 4
    add(0, 0, 1, 32'hfff0010c, 0, 0, 0,  1, 32'hfff0010c, 1, 32'hfff00108, 32'hfff00108, 0);
    add(0, 0, 1, 32'hfff00110, 0, 0, 0,  1, 32'hfff00110, 1, 32'hfff00108, 32'hfff00108, 0);
    add(0, 0, 1, 32'hfff00114, 0, 0, 0,  1, 32'hfff00114, 1, 32'hfff00108, 32'hfff00108, 0);
    add(0, 0, 0, 32'h0,        0, 0, 0,  0, 32'hfff00118, 1, 32'hfff00108, 32'hfff00108, 0);
    add(0, 0, 0, 32'h0,        0, 1, 0,  0, 32'hfff00118, 1, 32'hfff00108, 32'hfff00108, 0);
    // Single pop re-raises strobe; cache stalls 5 cycles with request held
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 32'h0, 0, 0, 1,  1, 32'hfff00118, 1, 32'hfff0010c, 32'hfff0010c, 0);
    add(0, 0, 1, 32'hfff00118, 0, 0, 0,  1, 32'hfff00118, 1, 32'hfff0010c, 32'hfff0010c, 0);
    add(0, 0, 0, 32'h0,        0, 1, 0,  0, 32'hfff0011c, 1, 32'hfff0010c, 32'hfff0010c, 0);
    add(0, 0, 0, 32'h0,        0, 1, 0,  1, 32'hfff0011c, 1, 32'hfff00110, 32'hfff00110, 0);
    add(0, 0, 0, 32'h0,        0, 1, 0,  1, 32'hfff0011c, 1, 32'hfff00114, 32'hfff00114, 0);
    add(0, 0, 0, 32'h0,        0, 1, 0,  1, 32'hfff0011c, 1, 32'hfff00118, 32'hfff00118, 0);
    // Redirect coinciding with completion goes straight to 0x1008
    add(1, 32'h1008, 1, 32'hfff0011c, 0, 1, 0,  1, 32'hfff0011c, 0, 0, 0, 0);
    // Redirect to 0x2000 with 0x1008 outstanding: held, dropped, then 0x2000
    add(1, 32'h2000, 0, 32'h0,        0, 1, 0,  1, 32'h1008, 0, 0, 0, 0);
    add(0, 0,        0, 32'h0,        0, 1, 1,  1, 32'h1008, 0, 0, 0, 0);
    add(0, 0,        1, 32'hdeadbeef, 0, 1, 0,  1, 32'h1008, 0, 0, 0, 0);
    add(0, 0,        1, 32'h2000,     0, 1, 0,  1, 32'h2000, 0, 0, 0, 0);
    add(0, 0,        0, 32'h0,        0, 1, 0,  1, 32'h2004, 1, 32'h2000, 32'h2000, 0);
    // Fault at 0x3000: entry with zero instr, strobe low until redirect to 0x700
    add(1, 32'h3000, 1, 32'h2004,     0, 1, 0,  1, 32'h2004, 0, 0, 0, 0);
    add(0, 0,        1, 32'h1234,     2, 0, 0,  1, 32'h3000, 0, 0, 0, 0);
    add(0, 0,        0, 32'h0,        0, 1, 0,  0, 32'h3000, 1, 32'h3000, 32'h0, 2);
    add(0, 0,        0, 32'h0,        0, 1, 0,  0, 32'h3000, 0, 0, 0, 0);
    add(1, 32'h700,  0, 32'h0,        0, 1, 0,  0, 32'h3000, 0, 0, 0, 0);
    // Address wrap past 0xfffffffc, then unaligned redirect target
    add(1, 32'hfffffffc, 1, 32'h700,  0, 1, 0,  1, 32'h700, 0, 0, 0, 0);
    add(0, 0,        1, 32'haaaa5555, 0, 0, 0,  1, 32'hfffffffc, 0, 0, 0, 0);
    add(1, 32'h1003, 1, 32'h0,        0, 0, 0,  1, 32'h0, 1, 32'hfffffffc, 32'haaaa5555, 0);
    add(0, 0,        0, 32'h0,        0, 0, 0,  1, 32'h1000, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_strobe", 32'(ic_read_strobe), 32'h0);
    chk("rst_addr",   ic_read_addr, 32'hfff00100);
    chk("rst_valid",  32'(out_valid), 32'h0);
    chk("rst_pc",     out_pc, 32'h0);
    chk("rst_instr",  out_instr, 32'h0);
    chk("rst_fault",  32'(out_fault), 32'h0);

    // Table replay
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].rd, vecs[i].ra, vecs[i].v, vecs[i].d, vecs[i].f,
            vecs[i].rdy, vecs[i].stl);
      #1;
      chk($sformatf("v%0d_strobe", i), 32'(ic_read_strobe), 32'(vecs[i].e_stb));
      chk($sformatf("v%0d_addr", i),   ic_read_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i),  32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_pc", i),     out_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i),  out_instr, vecs[i].e_ins);
      chk($sformatf("v%0d_fault", i),  32'(out_fault), 32'(vecs[i].e_flt));
    end

    // Second redirect while discarding replaces the pending target
    @(negedge clk); drive(0, 1, 32'h400, 0, 32'h0, 0, 1, 1); #1;
    chk("rr_addr0", ic_read_addr, 32'h1000);
    chk("rr_stb0",  32'(ic_read_strobe), 32'h1);
    @(negedge clk); drive(0, 1, 32'h501, 0, 32'h0, 0, 1, 1); #1;
    chk("rr_addr1", ic_read_addr, 32'h1000);
    chk("rr_stb1",  32'(ic_read_strobe), 32'h1);
    @(negedge clk); drive(0, 0, 32'h0, 1, 32'h11, 0, 1, 0); #1;
    chk("rr_addr2", ic_read_addr, 32'h1000);
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 0); #1;
    chk("rr_addr3", ic_read_addr, 32'h500);
    chk("rr_valid", 32'(out_valid), 32'h0);

    // Reset during an outstanding request
    @(negedge clk); drive(1, 0, 32'h0, 0, 32'h0, 0, 1, 1); #1;
    chk("mr_stb0",  32'(ic_read_strobe), 32'h0);
    chk("mr_addr0", ic_read_addr, 32'h500);
    @(negedge clk); drive(1, 0, 32'h0, 1, 32'h22, 0, 1, 0); #1;
    chk("mr_stb1",  32'(ic_read_strobe), 32'h0);
    chk("mr_addr1", ic_read_addr, 32'hfff00100);
    chk("mr_valid1", 32'(out_valid), 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 0); #1;
    chk("mr_stb2",  32'(ic_read_strobe), 32'h1);
    chk("mr_addr2", ic_read_addr, 32'hfff00100);
    @(negedge clk); #1;
    chk("mr_valid3", 32'(out_valid), 32'h0);
    chk("mr_addr3", ic_read_addr, 32'hfff00100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
